// File: rtl/clk_div_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ratio_ctrl
//
// Ratio-change controller for the programmable clock divider. Two requesters
// ask for a new divide ratio. The block picks one round-robin and holds the
// divider disabled for a drain window. It then loads the new ratio, waits a
// settle window with the divider running again, and acknowledges. The divider
// never sees a ratio change while it is enabled.
//
// Optional feature (compile-time macro RATIO_RANGE_CHECK_EN):
//   defined   - a captured ratio of 0 or 1 is rejected with a nackN pulse.
//               div_ratio and the run flag are left untouched.
//   undefined - no range check. nack0/nack1 are tied low.
//
// Ports
//   ref_clk          in   clock (single domain)
//   rst              in   asynchronous, active-low reset
//   sys_en           in   global divider enable from the system
//   req0 / req1      in   ratio-change request, requester 0 / 1
//   ratio0 / ratio1  in   requested ratio, valid while reqN is high
//   ack0 / ack1      out  one-cycle pulse: new ratio is live
//   nack0 / nack1    out  one-cycle pulse: request rejected (range check)
//   div_ratio        out  ratio driven to the divider
//   div_en           out  enable driven to the divider (sys_en & run)
//   busy             out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module clk_div_ratio_ctrl #(
    parameter int unsigned         RATIO_WD      = 8,
    parameter logic [RATIO_WD-1:0] DEFAULT_RATIO = RATIO_WD'(2),
    parameter int unsigned         DRAIN_CYC     = 2,
    parameter int unsigned         SETTLE_CYC    = 4
) (
    input  logic                ref_clk,
    input  logic                rst,
    input  logic                sys_en,
    input  logic                req0,
    input  logic                req1,
    input  logic [RATIO_WD-1:0] ratio0,
    input  logic [RATIO_WD-1:0] ratio1,
    output logic                ack0,
    output logic                ack1,
    output logic                nack0,
    output logic                nack1,
    output logic [RATIO_WD-1:0] div_ratio,
    output logic                div_en,
    output logic                busy
);

    // One counter serves both the drain and the settle windows.
    localparam int unsigned CNT_MAX = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_LOAD,
        S_SETTLE,
        S_ACK
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [RATIO_WD-1:0] pending;   // ratio captured at the grant edge
    logic                gnt_id;    // requester owning the current transaction
    logic                rr;        // tie-break: requester that wins the next tie
    logic                run;       // divider enable from the controller
    logic [1:0]          ack_q;
`ifdef RATIO_RANGE_CHECK_EN
    logic [1:0]          nack_q;
`endif

    // Grant selection, valid whenever at least one request is high in IDLE.
    logic                gnt_sel;
    logic [RATIO_WD-1:0] gnt_ratio;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt_sel = 1'b0;
        if (req0 && req1) begin
            gnt_sel = rr;
        end else if (req1) begin
            gnt_sel = 1'b1;
        end
        gnt_ratio = gnt_sel ? ratio1 : ratio0;
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pending   <= DEFAULT_RATIO;
            gnt_id    <= 1'b0;
            rr        <= 1'b0;
            run       <= 1'b1;
            div_ratio <= DEFAULT_RATIO;
            ack_q     <= '0;
            busy      <= 1'b0;
`ifdef RATIO_RANGE_CHECK_EN
            nack_q    <= '0;
`endif
        end else begin
            // NOTE: all state here uses non-blocking assignments. Every
            // register then sees the values from before this edge, whatever
            // the statement order.
            ack_q <= '0;
`ifdef RATIO_RANGE_CHECK_EN
            nack_q <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        gnt_id  <= gnt_sel;
                        rr      <= ~gnt_sel;   // the loser gets the next tie
                        pending <= gnt_ratio;
                        busy    <= 1'b1;
                        cnt     <= '0;
`ifdef RATIO_RANGE_CHECK_EN
                        if (gnt_ratio < RATIO_WD'(2)) begin
                            // Rejected: go straight to ACK and leave the divider alone.
                            state          <= S_ACK;
                            nack_q[gnt_sel] <= 1'b1;
                        end else
`endif
                        if (gnt_ratio == div_ratio) begin
                            // Nothing to change: acknowledge without draining.
                            state          <= S_ACK;
                            ack_q[gnt_sel] <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                            run   <= 1'b0;
                        end
                    end
                end

                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_LOAD: begin
                    // The divider has been disabled for the full drain window.
                    div_ratio <= pending;
                    run       <= 1'b1;
                    state     <= S_SETTLE;
                    cnt       <= '0;
                end

                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state         <= S_ACK;
                        ack_q[gnt_id] <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_ACK: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    run   <= 1'b1;
                end
            endcase
        end
    end

    assign ack0   = ack_q[0];
    assign ack1   = ack_q[1];
    assign div_en = sys_en & run;

`ifdef RATIO_RANGE_CHECK_EN
    assign nack0 = nack_q[0];
    assign nack1 = nack_q[1];
`else
    assign nack0 = 1'b0;
    assign nack1 = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ratio_ctrl
//
// Self-checking bench for clk_div_ratio_ctrl.
//
// A transaction-level reference model schedules each request: grant cycle,
// ack/nack cycle, drain window and the cycle the new ratio appears. It writes
// per-cycle expectations and pushes the pulse it expects into a scoreboard.
// A monitor on the falling edge compares div_en, busy and div_ratio every
// cycle. It pops the scoreboard whenever an ack or nack pulse appears.
// -----------------------------------------------------------------------------
module tb_clk_div_ratio_ctrl;

    localparam int              RW        = 8;
    localparam int              DRAIN     = 2;
    localparam int              SETTLE    = 4;
    localparam logic [RW-1:0]   DEF_RATIO = 8'd2;
    localparam int              LAT       = DRAIN + SETTLE + 2;  // grant edge to ack cycle
    localparam int              MAXC      = 8192;
    localparam int              BUDGET    = 100;
`ifdef RATIO_RANGE_CHECK_EN
    localparam bit              RC        = 1'b1;
`else
    localparam bit              RC        = 1'b0;
`endif

    typedef struct {
        bit            id;
        bit            nack;
        int            cyc;
        logic [RW-1:0] ratio;
    } exp_t;

    logic          ref_clk = 1'b0;
    logic          rst     = 1'b0;
    logic          sys_en  = 1'b1;
    logic          req0    = 1'b0;
    logic          req1    = 1'b0;
    logic [RW-1:0] ratio0  = '0;
    logic [RW-1:0] ratio1  = '0;
    logic          ack0, ack1, nack0, nack1, div_en, busy;
    logic [RW-1:0] div_ratio;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   chk_en = 1'b0;

    // Reference model state.
    exp_t          exp_q[$];
    bit            exp_low[MAXC];
    bit            exp_busy[MAXC];
    logic [RW-1:0] exp_ratio[MAXC];
    logic [RW-1:0] m_ratio  = DEF_RATIO;
    bit            last_gnt = 1'b1;   // as if requester 1 was granted last, so req0 wins the first tie

    clk_div_ratio_ctrl #(
        .RATIO_WD      (RW),
        .DEFAULT_RATIO (DEF_RATIO),
        .DRAIN_CYC     (DRAIN),
        .SETTLE_CYC    (SETTLE)
    ) dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .sys_en    (sys_en),
        .req0      (req0),
        .req1      (req1),
        .ratio0    (ratio0),
        .ratio1    (ratio1),
        .ack0      (ack0),
        .ack1      (ack1),
        .nack0     (nack0),
        .nack1     (nack1),
        .div_ratio (div_ratio),
        .div_en    (div_en),
        .busy      (busy)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cyc <= cyc + 1;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    // One granted transaction. g is the first cycle after the grant edge.
    // a returns the cycle in which the ack/nack pulse is expected.
    task automatic txn(input bit id, input logic [RW-1:0] r, input int g, output int a);
        exp_t e;
        bit   rej;
        rej = RC && (r < 8'd2);
        if (rej || r == m_ratio) begin
            a = g;
        end else begin
            a = g + LAT - 1;
            for (int c = g; c <= g + DRAIN; c++) if (c < MAXC) exp_low[c] = 1'b1;
            for (int c = g + DRAIN + 1; c < MAXC; c++) exp_ratio[c] = r;
            m_ratio = r;
        end
        for (int c = g; c <= a; c++) if (c < MAXC) exp_busy[c] = 1'b1;
        e.id    = id;
        e.nack  = rej;
        e.cyc   = a;
        e.ratio = m_ratio;
        exp_q.push_back(e);
        last_gnt = id;
    endtask

    task automatic model_reset();
        m_ratio  = DEF_RATIO;
        last_gnt = 1'b1;
        exp_q.delete();
        for (int c = cyc; c < MAXC; c++) begin
            exp_low[c]   = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_ratio[c] = DEF_RATIO;
        end
    endtask

    function automatic logic [RW-1:0] pick();
        if ($urandom_range(0, 3) == 0) return m_ratio;
        return RW'($urandom_range(0, 12));
    endfunction

    // -------------------------------------------------------------- monitor
    always @(negedge ref_clk) begin : monitor
        exp_t e;
        if (chk_en && cyc < MAXC) begin
            check("div_en", 32'(div_en), 32'(sys_en & ~exp_low[cyc]));
            check("busy", 32'(busy), 32'(exp_busy[cyc]));
            check("div_ratio", 32'(div_ratio), 32'(exp_ratio[cyc]));
            if (ack0 | ack1 | nack0 | nack1) begin
                if (exp_q.size() == 0) begin
                    check("stray_pulse", {28'd0, ack1, ack0, nack1, nack0}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    check("pulse_id", 32'(ack1 | nack1), 32'(e.id));
                    check("pulse_is_nack", 32'(nack0 | nack1), 32'(e.nack));
                    check("pulse_count", 32'(int'(ack0) + int'(ack1) + int'(nack0) + int'(nack1)), 32'd1);
                    check("ratio_at_pulse", 32'(div_ratio), 32'(e.ratio));
                end
            end
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic start_edge();
        @(posedge ref_clk);
        #2;
    endtask

    task automatic drive_req(input bit id, input logic v, input logic [RW-1:0] r);
        if (id) begin
            req1   = v;
            ratio1 = r;
        end else begin
            req0   = v;
            ratio0 = r;
        end
    endtask

    // Raise a request and hold it until its ack/nack is seen.
    // Optionally change the ratio after alt_at cycles, to show it is ignored.
    task automatic hold_req(input bit id, input logic [RW-1:0] r,
                            input int alt_at, input logic [RW-1:0] alt_r);
        int n;
        bit done;
        drive_req(id, 1'b1, r);
        n    = 0;
        done = 1'b0;
        while (!done && n < BUDGET) begin
            @(posedge ref_clk);
            #2;
            n++;
            if (id ? (ack1 | nack1) : (ack0 | nack0)) done = 1'b1;
            else if (n == alt_at) drive_req(id, 1'b1, alt_r);
        end
        check(id ? "req1_completed" : "req0_completed", 32'(done), 32'd1);
        drive_req(id, 1'b0, id ? ratio1 : ratio0);
    endtask

    task automatic sc_single(input bit id, input logic [RW-1:0] r,
                             input int alt_at, input logic [RW-1:0] alt_r);
        int a;
        start_edge();
        txn(id, r, cyc + 1, a);
        hold_req(id, r, alt_at, alt_r);
    endtask

    // Both requesters raise together. With rereq, the first winner raises a
    // fresh request in its ack cycle, so the next grant is also contested.
    task automatic sc_tie(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                          input bit rereq, input logic [RW-1:0] r2);
        int            a;
        bit            w, w2;
        logic [RW-1:0] rw, rl;
        start_edge();
        w  = ~last_gnt;
        rw = w ? r1 : r0;
        rl = w ? r0 : r1;
        txn(w, rw, cyc + 1, a);
        if (rereq) begin
            w2 = ~last_gnt;
            txn(w2, (w2 == w) ? r2 : rl, a + 2, a);
            txn(~w2, (w2 == w) ? rl : r2, a + 2, a);
        end else begin
            txn(~w, rl, a + 2, a);
        end
        fork
            begin
                hold_req(w, rw, -1, '0);
                if (rereq) hold_req(w, r2, -1, '0);
            end
            hold_req(~w, rl, -1, '0);
        join
    endtask

    // Reset hits in the middle of SETTLE: everything returns to reset values
    // and the discarded transaction never acknowledges.
    task automatic reset_mid();
        logic [RW-1:0] r;
        r = (m_ratio == 8'd11) ? 8'd12 : 8'd11;
        start_edge();
        chk_en = 1'b0;
        drive_req(1'b0, 1'b1, r);
        repeat (DRAIN + 3) begin
            @(posedge ref_clk);
            #2;
        end
        check("busy_in_settle", 32'(busy), 32'd1);
        check("ratio_in_settle", 32'(div_ratio), 32'(r));
        check("div_en_in_settle", 32'(div_en), 32'(sys_en));
        rst = 1'b0;
        drive_req(1'b0, 1'b0, r);
        #1;
        check("rst_mid_div_ratio", 32'(div_ratio), 32'(DEF_RATIO));
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_div_en", 32'(div_en), 32'(sys_en));
        repeat (2) begin
            @(posedge ref_clk);
            #2;
            check("no_pulse_in_reset", {28'd0, ack1, ack0, nack1, nack0}, 32'd0);
        end
        rst = 1'b1;
        repeat (SETTLE + 2) begin
            @(posedge ref_clk);
            #2;
            check("no_pulse_after_reset", {28'd0, ack1, ack0, nack1, nack0}, 32'd0);
            check("idle_after_reset", 32'(busy), 32'd0);
        end
        model_reset();
        chk_en = 1'b1;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin : stim
        logic [RW-1:0] r0, r1, r2;
        int            kind;

        for (int c = 0; c < MAXC; c++) exp_ratio[c] = DEF_RATIO;

        // Reset values, including div_en following sys_en through run=1.
        rst    = 1'b0;
        sys_en = 1'b0;
        repeat (2) @(posedge ref_clk);
        #2;
        check("rst_div_ratio", 32'(div_ratio), 32'(DEF_RATIO));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", {28'd0, ack1, ack0, nack1, nack0}, 32'd0);
        check("rst_div_en_sys0", 32'(div_en), 32'(sys_en));
        sys_en = 1'b1;
        #1;
        check("rst_div_en_sys1", 32'(div_en), 32'(sys_en));
        @(posedge ref_clk);
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;

        // Directed cases.
        sc_single(1'b0, 8'd6, -1, '0);          // full sequence, ack 8 cycles on
        sc_tie(8'd4, 8'd5, 1'b1, 8'd7);         // tie -> req0; contested regrant -> req1
        sc_single(1'b1, m_ratio, -1, '0);       // same ratio: immediate ack, no drain
        sc_single(1'b0, 8'd1, -1, '0);          // range-check boundary
        sc_single(1'b0, 8'd3, 2, 8'd9);         // ratio changed during DRAIN is ignored
        reset_mid();
        sc_tie(8'd6, 8'd8, 1'b0, '0);           // after reset req0 wins the tie again
        sc_single(1'b1, 8'd0, -1, '0);          // zero ratio

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            sys_en = ($urandom_range(0, 3) != 0);
            r0     = pick();
            r1     = pick();
            r2     = pick();
            kind   = $urandom_range(0, 2);
            case (kind)
                0:       sc_single(1'($urandom_range(0, 1)), r0, -1, '0);
                1:       sc_tie(r0, r1, 1'b0, r2);
                default: sc_tie(r0, r1, 1'b1, r2);
            endcase
            repeat ($urandom_range(0, 3)) @(posedge ref_clk);
        end

        repeat (3) @(posedge ref_clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
